// File: rtl/cm_serial_mac_if.sv
// cm_serial_mac_if: operand stream in, saturated result stream out, plus window status.
interface cm_serial_mac_if #(
  parameter int DW = 8,
  parameter int OW = 8,
  parameter int KW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          signed_mode;
  logic [KW-1:0] klen;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out;
  logic          out_ovf;
  logic          busy;
  modport master (
    output in_valid, a, b, signed_mode, klen, out_ready,
    input  in_ready, out_valid, out, out_ovf, busy
  );
  modport slave (
    input  in_valid, a, b, signed_mode, klen, out_ready,
    output in_ready, out_valid, out, out_ovf, busy
  );
endinterface

// File: rtl/cm_serial_mac.sv
// cm_serial_mac: windowed serial multiply-accumulate with rescale and saturation.
module cm_serial_mac #(
  parameter int DW    = 8,
  parameter int AW    = 24,
  parameter int OW    = 8,
  parameter int KW    = 8,
  parameter int SHIFT = 0
) (
  input logic           clk,
  input logic           rst,
  cm_serial_mac_if.slave s
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  localparam logic [AW-1:0] SMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic [AW-1:0] SMIN = ~SMAX;
  localparam logic [AW-1:0] UMAX = {{(AW-OW){1'b0}}, {OW{1'b1}}};
  state_t          state, state_n;
  logic [2*DW-1:0] pu, ps;
  logic [AW-1:0]   prod, acc, acc_n, sh_s, sh_u, sh;
  logic [KW:0]     cnt, cnt_n, kl, klen_r;
  logic            sign_r, sgn, accept, first, last, hi, lo;
  logic [OW-1:0]   sat;
  assign accept = s.in_valid && s.in_ready;
  // A beat taken outside ACC opens a new window and latches its mode and length.
  assign first  = state != ACC;
  assign sgn    = first ? s.signed_mode : sign_r;
  assign kl     = first ? (s.klen == '0 ? (KW+1)'(1) : {1'b0, s.klen}) : klen_r;
  assign pu     = {{DW{1'b0}}, s.a} * {{DW{1'b0}}, s.b};
  assign ps     = {{DW{s.a[DW-1]}}, s.a} * {{DW{s.b[DW-1]}}, s.b};
  assign prod   = sgn ? {{(AW-2*DW){ps[2*DW-1]}}, ps} : {{(AW-2*DW){1'b0}}, pu};
  assign acc_n  = first ? prod : acc + prod;
  assign cnt_n  = first ? (KW+1)'(1) : cnt + 1'b1;
  assign last   = cnt_n == kl;
  assign sh_s   = $signed(acc_n) >>> SHIFT;
  assign sh_u   = acc_n >> SHIFT;
  assign sh     = sgn ? sh_s : sh_u;
  assign hi     = sgn ? $signed(sh) > $signed(SMAX) : sh > UMAX;
  assign lo     = sgn && $signed(sh) < $signed(SMIN);
  assign sat    = hi ? (sgn ? SMAX[OW-1:0] : UMAX[OW-1:0]) : lo ? SMIN[OW-1:0] : sh[OW-1:0];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = accept ? (last ? DONE : ACC) : (state == DONE && s.out_ready) ? IDLE : state;
  end
  always_comb begin
    s.in_ready  = state != DONE || s.out_ready;
    s.out_valid = state == DONE;
    s.busy      = state == ACC;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      klen_r    <= '0;
      sign_r    <= 1'b0;
      s.out     <= '0;
      s.out_ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_n;
      cnt <= cnt_n;
      if (first) begin
        klen_r <= kl;
        sign_r <= s.signed_mode;
      end
      if (last) begin
        s.out     <= sat;
        s.out_ovf <= hi || lo;
      end
    end
  end
endmodule

// File: doc/cm_serial_mac.md
Name: cm_serial_mac

Overview:
- Parametrised serial convolution MAC, successor to the fixed 8-bit single-PE serial accumulator.
- Accepts one (a, b) operand pair per handshake beat and accumulates a*b over a window of `klen` beats.
- At window end, emits one rescaled, saturated result on a valid/ready output port, then restarts automatically. This replaces the external mux-driven partial-sum clear.
- Sits between the operand streamer and the output line buffer in the computation PE array.

Parameters:
- DW, 8: operand width of a and b.
- AW, 24: accumulator width; must be >= 2*DW + KW.
- OW, 8: result width.
- KW, 8: width of the window-length input `klen`.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation; 0 <= SHIFT < AW.

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operand beat valid.
- in_ready, output, 1: block can accept an operand beat.
- a, input, DW: operand A.
- b, input, DW: operand B.
- signed_mode, input, 1: 1 = two's-complement operands and result; 0 = unsigned.
- klen, input, KW: beats per window; 0 is treated as 1.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts result.
- out, output, OW: saturated result.
- out_ovf, output, 1: saturation occurred for the current result.
- busy, output, 1: a window is in progress (state ACC).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc=0, cnt=0, out=0, out_valid=0, out_ovf=0, busy=0. Reset asserted mid-window discards the partial sum and any pending result.
- FSM states: IDLE, ACC, DONE.
- Accept condition: in_valid && in_ready.
- in_ready = 1 in IDLE and ACC. In DONE, in_ready = out_ready, so a result hand-off and the first beat of the next window can complete in the same cycle.
- First beat of a window (accepted in IDLE, or in DONE with out_ready=1):
  - latch klen_r = max(klen,1) and sign_r = signed_mode;
  - acc <= ext(a*b); cnt <= 1.
- Later beats (ACC): acc <= acc + ext(a*b); cnt <= cnt+1. signed_mode and klen changes mid-window are ignored.
- Product rule: full 2*DW-bit product, sign- or zero-extended to AW according to sign_r. The accumulator wraps modulo 2^AW; no overflow check inside the window.
- Window end: when the accepted beat makes cnt == klen_r, the next state is DONE, regardless of the current state. This includes a window with klen=1.
- Latency: last beat accepted at edge t; out_valid=1 and out valid after edge t (one cycle).
- Result computation, using the final acc including the last beat:
  - s = acc >>> SHIFT (arithmetic if sign_r, logical otherwise).
  - Signed: clip s to [-2^(OW-1), 2^(OW-1)-1].
  - Unsigned: clip s to [0, 2^OW-1].
  - out_ovf = 1 if clipping occurred.
- out and out_ovf are registered and held stable while out_valid && !out_ready.
- DONE exit:
  - out_ready=1 and no accept: go to IDLE, out_valid <= 0.
  - out_ready=1 and accept: go to ACC, or back to DONE if klen_r=1, starting the new window.
  - out_ready=0: hold.
- out_valid is never asserted in IDLE or ACC. out keeps its last value after hand-off.
- busy = (state == ACC).
- IDLE/ACC with in_valid=0: hold all state. Bubbles inside a window are legal.
- cnt width is KW+1, so klen = 2^KW-1 does not overflow.

Test Plan:
- Unsigned window: DW=8, OW=8, SHIFT=0, klen=3, pairs (2,3), (4,5), (1,1) back-to-back -> out_valid one cycle after the third beat, out=27, out_ovf=0.
- Signed saturation: signed_mode=1, klen=2, pairs (-128,-128), (100,100) -> acc=26384, out=127, out_ovf=1. Repeat with (-128,127), (-1,1) -> out=-128, out_ovf=1.
- Backpressure and overlap: klen=1, in_valid held high, out_ready low for 3 cycles then high -> in_ready=0 while stalled, out stable; on release, the hand-off and the next beat are accepted in the same cycle; no beat is lost or duplicated.
- Bubbles and mid-window changes: klen=4 with in_valid gaps; change signed_mode and klen after beat 1 -> the result uses the latched values and exactly 4 accepted beats.
- klen=0 and SHIFT: klen=0, pair (10,10), SHIFT=2 -> treated as one beat, out=25.
- Async reset mid-window: rst low between beats 2 and 3 of a klen=4 window -> immediate IDLE, outputs 0; the next full window's result excludes the old partial sum.
